pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline-stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries a DATA_W payload (PC, operands, immediate, rd) and a CTRL_W control bundle (ALUOp, MemRead/MemWrite, RegWrite, PCSource, ...).
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and throughput stays full.
- Adds synchronous flush for branch squash, bubble injection on control fields, and a saturating stall-cycle counter.

---
 rtl/pipe_stage_reg_pkg.sv | 28 ++
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 132 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Definitions shared by the elastic pipeline-stage register: word size, control-bundle
// field layout, the NOP control encoding and the stage occupancy states.
package pipe_stage_reg_pkg;

    localparam int WORD_SIZE = 16;

    // Control-bundle layout, LSB offsets and widths
    localparam int ALUOP_LSB    = 0;
    localparam int ALUOP_W      = 3;
    localparam int ALUSRCB_LSB  = 3;
    localparam int ALUSRCB_W    = 2;
    localparam int MEMREAD_BIT  = 5;
    localparam int MEMWRITE_BIT = 6;
    localparam int BOP_BIT      = 7;
    localparam int REGWRITE_BIT = 8;
    localparam int PCSOURCE_LSB = 9;
    localparam int PCSOURCE_W   = 2;

    // All-zero control is a NOP: no RegWrite, no MemWrite, sequential PC
    localparam logic [15:0] CTRL_NOP = 16'h0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones and is cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable elastic pipeline register: valid/ready handshake with a two-entry skid
// buffer, synchronous flush, bubble control on empty output and a stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W      = 48,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(CTRL_NOP),
    parameter int                CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    if ((DATA_W < 1) || (CTRL_W < 1) || (CNT_W < 1)) begin : g_badParam
        $error("pipe_stage_reg: DATA_W, CTRL_W and CNT_W must all be at least 1");
    end

    stage_state_t      r_state;
    stage_state_t      w_nextState;
    logic              w_inFire;
    logic              w_outFire;
    logic              w_loadMainIn;
    logic              w_loadSkid;
    logic              w_loadMainSkid;
    logic              w_stallInc;
    logic [DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0] r_skidCtrl;

    // in_ready is decoded from the registered state; only flush and reset gate it
    assign in_ready  = (r_state != FULL) & ~flush & ~Reset;
    assign out_valid = (r_state != EMPTY);
    assign w_inFire  = in_valid & in_ready;
    assign w_outFire = out_valid & out_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadSkid     = 1'b0;
        w_loadMainSkid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_loadMainIn = 1'b1;
                    w_nextState  = ONE;
                end
            end
            ONE: begin
                if (w_inFire && w_outFire) begin
                    w_loadMainIn = 1'b1;
                end else if (w_inFire) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = FULL;
                end else if (w_outFire) begin
                    w_nextState = EMPTY;
                end
            end
            FULL: begin
                if (w_outFire) begin
                    w_loadMainSkid = 1'b1;
                    w_nextState    = ONE;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
        // Squash wins over any transfer; held data is simply abandoned
        if (flush) begin
            w_nextState    = EMPTY;
            w_loadMainIn   = 1'b0;
            w_loadSkid     = 1'b0;
            w_loadMainSkid = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_mainData <= '0;
            r_mainCtrl <= BUBBLE_CTRL;
            r_skidData <= '0;
            r_skidCtrl <= BUBBLE_CTRL;
        end else begin
            if (w_loadMainIn) begin
                r_mainData <= in_data;
                r_mainCtrl <= in_ctrl;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
                r_mainCtrl <= r_skidCtrl;
            end
            if (w_loadSkid) begin
                r_skidData <= in_data;
                r_skidCtrl <= in_ctrl;
            end
        end
    end

    assign out_data = r_mainData;
    assign out_ctrl = out_valid ? r_mainCtrl : BUBBLE_CTRL;

    assign w_stallInc = out_valid & ~out_ready & ~flush;

    sat_counter #(
        .W(CNT_W)
    ) u_stallCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (w_stallInc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DW = 48;
    localparam int CW = 16;
    localparam int SW = 4;
    localparam int SAT = 15;

    logic          Clk;
    logic          Reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [SW-1:0] stall_cnt;

    pipe_stage_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .BUBBLE_CTRL ({CW{1'b0}}),
        .CNT_W       (SW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of at most two entries
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;
    ent_t mq[$];
    int   mCnt = 0;
    bit   lastInFire = 0;

    function automatic bit expIr();
        return (mq.size() < 2) && !flush && !Reset;
    endfunction

    function automatic bit expOv();
        return mq.size() > 0;
    endfunction

    function automatic logic [CW-1:0] expCtrl();
        return (mq.size() > 0) ? mq[0].c : {CW{1'b0}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic ordy, input logic fl,
                                 input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
        in_ctrl   = c;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        bit   inF;
        bit   outF;
        bit   st;
        bit   fl;
        ent_t e;
        inF = in_valid && expIr();
        outF = expOv() && out_ready;
        st = expOv() && !out_ready && !flush;
        fl = flush;
        e.d = in_data;
        e.c = in_ctrl;
        @(posedge Clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (outF) void'(mq.pop_front());
            if (inF) mq.push_back(e);
        end
        if (st && mCnt < SAT) mCnt++;
        lastInFire = inF;
        #1;
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(expIr()));
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(expOv()));
        checkOutput({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(expCtrl()));
        checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(mCnt));
        if (expOv()) checkOutput({tag, ".out_data"}, 64'(out_data), 64'(mq[0].d));
    endtask

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          eIr;
        logic          eOv;
        logic          chkD;
        logic [DW-1:0] eD;
        logic [CW-1:0] eC;
        logic [SW-1:0] eSt;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [DW-1:0] rd;
        logic [CW-1:0] rc;
        logic          riv;
        logic          rordy;
        logic          rfl;

        // Backpressure, skid drain and flush-while-full, expectations worked by hand
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 48'hA, 16'h0A0A, 1'b1, 1'b0, 1'b0, 48'h0, 16'h0,    4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 48'hB, 16'h0B0B, 1'b1, 1'b1, 1'b1, 48'hA, 16'h0A0A, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 48'hC, 16'h0C0C, 1'b0, 1'b1, 1'b1, 48'hA, 16'h0A0A, 4'd1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 48'hC, 16'h0C0C, 1'b0, 1'b1, 1'b1, 48'hA, 16'h0A0A, 4'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 48'h0, 16'h0,    1'b0, 1'b1, 1'b1, 48'hA, 16'h0A0A, 4'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 48'h0, 16'h0,    1'b1, 1'b1, 1'b1, 48'hB, 16'h0B0B, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 48'h0, 16'h0,    1'b1, 1'b0, 1'b0, 48'h0, 16'h0,    4'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 48'hD, 16'h0D0D, 1'b1, 1'b0, 1'b0, 48'h0, 16'h0,    4'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 48'hE, 16'h0E0E, 1'b1, 1'b1, 1'b1, 48'hD, 16'h0D0D, 4'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 48'h0, 16'h0,    1'b0, 1'b1, 1'b1, 48'hD, 16'h0D0D, 4'd4};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 48'h0, 16'h0,    1'b1, 1'b0, 1'b0, 48'h0, 16'h0,    4'd4};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 48'hF, 16'h0F0F, 1'b1, 1'b0, 1'b0, 48'h0, 16'h0,    4'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 48'h0, 16'h0,    1'b1, 1'b1, 1'b1, 48'hF, 16'h0F0F, 4'd4};

        // Initial reset
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge Clk);
        #2;
        checkOutput("rst.out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst.in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst.out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst.stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("rel.in_ready", 64'(in_ready), 64'd1);
        @(posedge Clk);
        #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d, vecs[i].c);
            @(negedge Clk);
            checkOutput($sformatf("tbl%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].eIr));
            checkOutput($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].eOv));
            checkOutput($sformatf("tbl%0d.out_ctrl", i), 64'(out_ctrl), 64'(vecs[i].eC));
            checkOutput($sformatf("tbl%0d.stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].eSt));
            if (vecs[i].chkD) checkOutput($sformatf("tbl%0d.out_data", i), 64'(out_data), 64'(vecs[i].eD));
            tick();
        end

        // Streaming: simultaneous in/out fire every cycle, in_ready never drops
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 48'(k), 16'(k) | 16'h8000);
            @(negedge Clk);
            checkOutput($sformatf("stream%0d.in_ready", k), 64'(in_ready), 64'd1);
            if (k > 1) begin
                checkOutput($sformatf("stream%0d.out_valid", k), 64'(out_valid), 64'd1);
                checkOutput($sformatf("stream%0d.out_data", k), 64'(out_data), 64'(k - 1));
                checkOutput($sformatf("stream%0d.out_ctrl", k), 64'(out_ctrl), 64'((k - 1) | 16'h8000));
            end
            tick();
        end

        // Saturation: hold the last streamed entry for 20 cycles
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge Clk);
        checkOutput("sat.out_data", 64'(out_data), 64'd16);
        repeat (20) tick();
        @(negedge Clk);
        checkOutput("sat.stall_cnt", 64'(stall_cnt), 64'(SAT));
        tick();
        @(negedge Clk);
        checkOutput("sat.hold", 64'(stall_cnt), 64'(SAT));
        checkOutput("sat.out_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset in the middle of a cycle while in_valid is high
        applyStimulus(1'b1, 1'b0, 1'b0, 48'h1234, 16'h00FF);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        mq.delete();
        mCnt = 0;
        #1;
        checkOutput("midrst.out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst.in_ready", 64'(in_ready), 64'd0);
        checkOutput("midrst.out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("midrst.stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge Clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("midrel.in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrel.stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge Clk);
        #1;

        // Randomized run; upstream keeps its entry stable until it is accepted
        lastInFire = 1'b0;
        riv = 1'b0;
        rd = '0;
        rc = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(riv && !lastInFire)) begin
                riv = ($urandom_range(0, 3) != 0);
                rd = {$urandom(), $urandom()};
                rc = 16'($urandom());
            end
            rordy = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if (n % 50 > 40) rordy = 1'b0;
            rfl = ($urandom_range(0, 24) == 0);
            applyStimulus(riv, rordy, rfl, rd, rc);
            @(negedge Clk);
            checkAgainstModel($sformatf("rnd%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
